// File: rtl/vga_scale_addr_gen.sv
// Scaled BRAM read-address generator for a VGA frame buffer.
// Walks a source image with fixed-point column/row steps, clamps at the
// source edges and emits a registered BRAM address one cycle after each event.
// LINE_START and FRAME_START are registered, so they appear one cycle after
// the HS edge / first VS cycle, aligned with BRAM_ADDR.
// Freeze mode (MODE 2/3) leaves the walk counters untouched and pins the
// address to the frame's base.
module vga_scale_addr_gen #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned SRC_W  = 128,
    parameter int unsigned SRC_H  = 100
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              VGA_HS,
    input  logic              VGA_VS,
    input  logic              VGA_VISIBLE,
    input  logic              VGA_VISIBLE_Y,
    input  logic [1:0]        MODE,
    input  logic [FRAC_W+1:0] X_STEP,
    input  logic [FRAC_W+1:0] Y_STEP,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] STRIDE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              LINE_START,
    output logic              FRAME_START
);

    localparam int unsigned STEP_W = FRAC_W + 2;
    localparam int unsigned ACC_W  = FRAC_W + 3;
    localparam int unsigned COL_W  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int unsigned ROW_W  = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int unsigned COLX_W = COL_W + 3;
    localparam int unsigned ROWX_W = ROW_W + 3;

    localparam logic [STEP_W-1:0] ONE_STEP = {2'b01, {FRAC_W{1'b0}}};
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(SRC_W - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(SRC_H - 1);

    // Frame-latched copies of the programming inputs
    logic [1:0]        mode_q, mode_d;
    logic [STEP_W-1:0] x_step_q, x_step_d;
    logic [STEP_W-1:0] y_step_q, y_step_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;

    // Walk state
    logic              old_hs_q, old_hs_d;
    logic              old_vs_q, old_vs_d;
    logic              first_line_q, first_line_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [FRAC_W-1:0] x_acc_q, x_acc_d;
    logic [FRAC_W-1:0] y_acc_q, y_acc_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              line_start_q, line_start_d;
    logic              frame_start_q, frame_start_d;

    // Datapath intermediates
    logic              hs_edge_c;
    logic              freeze_c;
    logic [STEP_W-1:0] x_step_c, y_step_c;
    logic [ACC_W-1:0]  x_sum_c, y_sum_c;
    logic [COLX_W-1:0] col_sum_c;
    logic [COL_W-1:0]  col_next_c;
    logic [ROWX_W-1:0] row_sum_c;
    logic [ROW_W-1:0]  row_next_c;
    logic [2:0]        row_delta_c;
    logic [ADDR_W-1:0] stride_add_c;
    logic [ADDR_W-1:0] addr_col_c;

    // Step accumulation, edge clamping and shift-add row-base advance
    always_comb begin
        hs_edge_c   = old_hs_q & ~VGA_HS;
        freeze_c    = mode_q[1];
        x_step_c    = (mode_q == 2'd1) ? ONE_STEP : x_step_q;
        y_step_c    = (mode_q == 2'd1) ? ONE_STEP : y_step_q;
        x_sum_c     = {3'b000, x_acc_q} + {1'b0, x_step_c};
        y_sum_c     = {3'b000, y_acc_q} + {1'b0, y_step_c};
        col_sum_c   = {3'b000, col_q} + COLX_W'(x_sum_c[ACC_W-1:FRAC_W]);
        col_next_c  = (col_sum_c > {3'b000, COL_MAX}) ? COL_MAX : col_sum_c[COL_W-1:0];
        row_sum_c   = {3'b000, row_q} + ROWX_W'(y_sum_c[ACC_W-1:FRAC_W]);
        row_next_c  = (row_sum_c > {3'b000, ROW_MAX}) ? ROW_MAX : row_sum_c[ROW_W-1:0];
        row_delta_c = 3'(row_next_c - row_q);
        stride_add_c = (row_delta_c[0] ? stride_q : '0)
                     + (row_delta_c[1] ? (stride_q << 1) : '0)
                     + (row_delta_c[2] ? (stride_q << 2) : '0);
        addr_col_c  = row_base_q + ADDR_W'(col_q);
    end

    // Per-cycle event priority: VS, visible-line HS edge, visible pixel, hold
    always_comb begin
        mode_d        = mode_q;
        x_step_d      = x_step_q;
        y_step_d      = y_step_q;
        base_d        = base_q;
        stride_d      = stride_q;
        old_hs_d      = old_hs_q;
        old_vs_d      = old_vs_q;
        first_line_d  = first_line_q;
        row_d         = row_q;
        col_d         = col_q;
        x_acc_d       = x_acc_q;
        y_acc_d       = y_acc_q;
        row_base_d    = row_base_q;
        addr_d        = addr_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (ENABLE) begin
            old_hs_d      = VGA_HS;
            old_vs_d      = VGA_VS;
            frame_start_d = VGA_VS & ~old_vs_q;

            if (VGA_VS) begin
                mode_d       = MODE;
                x_step_d     = X_STEP;
                y_step_d     = Y_STEP;
                base_d       = BASE_ADDR;
                stride_d     = STRIDE;
                row_d        = '0;
                col_d        = '0;
                x_acc_d      = '0;
                y_acc_d      = '0;
                row_base_d   = BASE_ADDR;
                addr_d       = BASE_ADDR;
                first_line_d = 1'b1;
            end else if (hs_edge_c && VGA_VISIBLE_Y) begin
                line_start_d = 1'b1;
                if (freeze_c) begin
                    addr_d = base_q;
                end else if (first_line_q) begin
                    first_line_d = 1'b0;
                    col_d        = '0;
                    x_acc_d      = '0;
                    addr_d       = row_base_q;
                end else begin
                    y_acc_d    = y_sum_c[FRAC_W-1:0];
                    row_d      = row_next_c;
                    row_base_d = row_base_q + stride_add_c;
                    col_d      = '0;
                    x_acc_d    = '0;
                    addr_d     = row_base_q + stride_add_c;
                end
            end else if (VGA_VISIBLE) begin
                if (freeze_c) begin
                    addr_d = base_q;
                end else begin
                    addr_d  = addr_col_c;
                    x_acc_d = x_sum_c[FRAC_W-1:0];
                    col_d   = col_next_c;
                end
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mode_q        <= '0;
            x_step_q      <= '0;
            y_step_q      <= '0;
            base_q        <= '0;
            stride_q      <= '0;
            old_hs_q      <= 1'b0;
            old_vs_q      <= 1'b0;
            first_line_q  <= 1'b1;
            row_q         <= '0;
            col_q         <= '0;
            x_acc_q       <= '0;
            y_acc_q       <= '0;
            row_base_q    <= '0;
            addr_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            x_step_q      <= x_step_d;
            y_step_q      <= y_step_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            old_hs_q      <= old_hs_d;
            old_vs_q      <= old_vs_d;
            first_line_q  <= first_line_d;
            row_q         <= row_d;
            col_q         <= col_d;
            x_acc_q       <= x_acc_d;
            y_acc_q       <= y_acc_d;
            row_base_q    <= row_base_d;
            addr_q        <= addr_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign BRAM_ADDR   = addr_q;
    assign LINE_START  = line_start_q;
    assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_scale_addr_gen.sv
// Self-checking bench for vga_scale_addr_gen against an arithmetic frame-walk model.
module tb_vga_scale_addr_gen;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned SRC_W  = 16;
    localparam int unsigned SRC_H  = 8;
    localparam int          AMOD   = 1 << ADDR_W;
    localparam int          ONE    = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              hs, vs, vis, visy;
    logic [1:0]        mode;
    logic [FRAC_W+1:0] xs, ys;
    logic [ADDR_W-1:0] base, stride;
    logic [ADDR_W-1:0] addr;
    logic              ls, fs;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers)
    int m_row, m_col, m_xacc, m_yacc, m_rb, m_first, m_ohs, m_ovs;
    int s_mode, s_xs, s_ys, s_base, s_stride;
    int m_addr, m_ls, m_fs;

    vga_scale_addr_gen #(
        .ADDR_W(ADDR_W), .FRAC_W(FRAC_W), .SRC_W(SRC_W), .SRC_H(SRC_H)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(en),
        .VGA_HS(hs), .VGA_VS(vs), .VGA_VISIBLE(vis), .VGA_VISIBLE_Y(visy),
        .MODE(mode), .X_STEP(xs), .Y_STEP(ys),
        .BASE_ADDR(base), .STRIDE(stride),
        .BRAM_ADDR(addr), .LINE_START(ls), .FRAME_START(fs)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_row = 0; m_col = 0; m_xacc = 0; m_yacc = 0; m_rb = 0; m_first = 1;
        m_ohs = 0; m_ovs = 0; s_mode = 0; s_xs = 0; s_ys = 0; s_base = 0;
        s_stride = 0; m_addr = 0; m_ls = 0; m_fs = 0;
    endtask

    // One clock of the frame walk, computed from the current inputs
    task automatic model_step();
        int st, t, nr, nc;
        if (!rst_n) begin
            model_reset();
        end else if (!en) begin
            m_ls = 0; m_fs = 0;
        end else begin
            m_fs = (vs && !m_ovs) ? 1 : 0;
            m_ls = 0;
            if (vs) begin
                s_mode = int'(mode); s_xs = int'(xs); s_ys = int'(ys);
                s_base = int'(base); s_stride = int'(stride);
                m_row = 0; m_col = 0; m_xacc = 0; m_yacc = 0;
                m_rb = int'(base); m_addr = int'(base); m_first = 1;
            end else if (m_ohs != 0 && !hs && visy) begin
                m_ls = 1;
                if (s_mode >= 2) begin
                    m_addr = s_base;
                end else if (m_first != 0) begin
                    m_first = 0; m_col = 0; m_xacc = 0; m_addr = m_rb;
                end else begin
                    st = (s_mode == 1) ? ONE : s_ys;
                    t  = m_yacc + st;
                    nr = m_row + t / ONE;
                    if (nr > int'(SRC_H) - 1) nr = int'(SRC_H) - 1;
                    m_yacc = t % ONE;
                    m_rb   = (m_rb + (nr - m_row) * s_stride) % AMOD;
                    m_row  = nr; m_col = 0; m_xacc = 0; m_addr = m_rb;
                end
            end else if (vis) begin
                if (s_mode >= 2) begin
                    m_addr = s_base;
                end else begin
                    m_addr = (m_rb + m_col) % AMOD;
                    st = (s_mode == 1) ? ONE : s_xs;
                    t  = m_xacc + st;
                    nc = m_col + t / ONE;
                    if (nc > int'(SRC_W) - 1) nc = int'(SRC_W) - 1;
                    m_xacc = t % ONE;
                    m_col  = nc;
                end
            end
            m_ohs = hs ? 1 : 0;
            m_ovs = vs ? 1 : 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Canonical frame timing: VS block, then lines with HS low for 2 cycles and npix visible pixels
    task automatic set_frame(input int c, input int vs_len, input int npix);
        int p;
        if (c < vs_len) begin
            vs = 1'b1; hs = 1'b1; vis = 1'b0; visy = 1'b0;
        end else begin
            p = (c - vs_len) % (npix + 4);
            vs = 1'b0; visy = 1'b1;
            hs = (p >= 2);
            vis = (p >= 3 && p < 3 + npix);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; hs = 1'b1; vs = 1'b0; vis = 1'b0; visy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_inputs();
        mode = 2'd0; xs = '0; ys = '0; base = 14'h155; stride = 14'd16;
        model_reset();
        #3;
        checks++;
        if ({addr, ls, fs} !== {ADDR_W'(0), 2'b00}) begin
            errors++; $display("FAIL reset_state got %h/%b/%b exp 0/0/0", addr, ls, fs);
        end
        tick(); tick();
        rst_n = 1'b1;
        vis = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)} || addr !== '0) begin
                errors++; $display("FAIL post_reset_idle got %h/%b/%b exp %h/%0d/%0d", addr, ls, fs, m_addr, m_ls, m_fs);
            end
        end
        vis = 1'b0;
    endtask

    task automatic test_native();
        int p, l;
        mode = 2'd1; base = '0; stride = 14'd128; xs = 10'h080; ys = 10'h080;
        for (int c = 0; c < 3 + 3 * 8; c++) begin
            set_frame(c, 3, 4);
            tick();
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                errors++; $display("FAIL native c=%0d got %h/%b/%b exp %h/%0d/%0d", c, addr, ls, fs, m_addr, m_ls, m_fs);
            end
            if (c >= 3) begin
                l = (c - 3) / 8; p = (c - 3) % 8;
                if (l == 1 && p >= 3 && p <= 6) begin
                    checks++;
                    if (addr !== ADDR_W'(128 + p - 3)) begin
                        errors++; $display("FAIL native_row1 pix=%0d got %0d exp %0d", p - 3, addr, 128 + p - 3);
                    end
                end
            end
        end
    endtask

    task automatic test_scaled();
        int p, l;
        mode = 2'd0; base = '0; stride = 14'd128; xs = 10'h080; ys = 10'h080;
        for (int c = 0; c < 2 + 4 * 10; c++) begin
            set_frame(c, 2, 6);
            tick();
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                errors++; $display("FAIL scaled c=%0d got %h/%b/%b exp %h/%0d/%0d", c, addr, ls, fs, m_addr, m_ls, m_fs);
            end
            if (c >= 2) begin
                l = (c - 2) / 10; p = (c - 2) % 10;
                if (p == 0) begin
                    checks++;
                    if (addr !== ADDR_W'((l >= 2) ? 128 : 0)) begin
                        errors++; $display("FAIL scaled_rowbase line=%0d got %0d exp %0d", l, addr, (l >= 2) ? 128 : 0);
                    end
                end
                if (l == 0 && p >= 3 && p <= 8) begin
                    checks++;
                    if (addr !== ADDR_W'((p - 3) / 2)) begin
                        errors++; $display("FAIL scaled_x pix=%0d got %0d exp %0d", p - 3, addr, (p - 3) / 2);
                    end
                end
            end
        end
    endtask

    task automatic test_clamp();
        int p, l, ec;
        mode = 2'd0; base = 14'd100; stride = 14'd16; xs = 10'h200; ys = 10'h200;
        for (int c = 0; c < 2 + 6 * 24; c++) begin
            set_frame(c, 2, 20);
            tick();
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                errors++; $display("FAIL clamp c=%0d got %h/%b/%b exp %h/%0d/%0d", c, addr, ls, fs, m_addr, m_ls, m_fs);
            end
            if (c >= 2) begin
                l = (c - 2) / 24; p = (c - 2) % 24;
                if (l == 0 && p >= 3 && p < 23) begin
                    ec = 2 * (p - 3);
                    if (ec > int'(SRC_W) - 1) ec = int'(SRC_W) - 1;
                    checks++;
                    if (addr !== ADDR_W'(100 + ec)) begin
                        errors++; $display("FAIL clamp_col pix=%0d got %0d exp %0d", p - 3, addr, 100 + ec);
                    end
                end
            end
        end
    endtask

    task automatic test_shadow();
        int fs_count;
        mode = 2'd0; base = 14'd40; stride = 14'd20; xs = 10'h100; ys = 10'h100;
        fs_count = 0;
        for (int c = 0; c < 3 + 3 * 12; c++) begin
            set_frame(c, 3, 8);
            if (c == 12) begin
                xs = 10'h300; ys = 10'h040; mode = 2'd2; base = 14'd999; stride = 14'd7;
            end
            if (c == 30) vs = 1'b1;
            tick();
            if (fs) fs_count++;
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                errors++; $display("FAIL shadow c=%0d got %h/%b/%b exp %h/%0d/%0d", c, addr, ls, fs, m_addr, m_ls, m_fs);
            end
        end
        for (int c = 0; c < 3 + 2 * 12; c++) begin
            set_frame(c, 3, 8);
            tick();
            if (fs) fs_count++;
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                errors++; $display("FAIL freeze c=%0d got %h/%b/%b exp %h/%0d/%0d", c, addr, ls, fs, m_addr, m_ls, m_fs);
            end
            if (c >= 3 && !vs) begin
                checks++;
                if (addr !== ADDR_W'(999)) begin
                    errors++; $display("FAIL freeze_base c=%0d got %0d exp 999", c, addr);
                end
            end
        end
        checks++;
        if (fs_count != 3) begin
            errors++; $display("FAIL frame_start_count got %0d exp 3", fs_count);
        end
    endtask

    task automatic test_enable();
        int held;
        mode = 2'd0; base = 14'd0; stride = 14'd32; xs = 10'h0C0; ys = 10'h100;
        for (int c = 0; c < 2 + 3 * 16; c++) begin
            set_frame(c, 2, 12);
            if (c == 2 + 16 + 7) begin
                en = 1'b0;
                held = m_addr;
                for (int k = 0; k < 10; k++) begin
                    hs = (k % 2 == 0); vis = (k % 3 != 0);
                    tick();
                    checks++;
                    if ({addr, ls, fs} !== {ADDR_W'(held), 2'b00}) begin
                        errors++; $display("FAIL enable_hold k=%0d got %h/%b/%b exp %h/0/0", k, addr, ls, fs, held);
                    end
                end
                en = 1'b1;
                set_frame(c, 2, 12);
            end
            tick();
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                errors++; $display("FAIL enable c=%0d got %h/%b/%b exp %h/%0d/%0d", c, addr, ls, fs, m_addr, m_ls, m_fs);
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 2'd0; base = 14'd300; stride = 14'd16; xs = 10'h100; ys = 10'h100;
        for (int c = 0; c < 2 + 16 + 6; c++) begin
            set_frame(c, 2, 10);
            tick();
        end
        checks++;
        if (addr === '0) begin
            errors++; $display("FAIL async_pre got %h exp nonzero", addr);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({addr, ls, fs} !== {ADDR_W'(0), 2'b00}) begin
            errors++; $display("FAIL async_reset got %h/%b/%b exp 0/0/0", addr, ls, fs);
        end
        tick();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (addr !== '0) begin
            errors++; $display("FAIL async_release got %h exp 0", addr);
        end
        idle_inputs();
        model_reset();
        m_ohs = 1;
        tick();
        for (int c = 0; c < 2 + 2 * 14; c++) begin
            set_frame(c, 2, 10);
            tick();
            checks++;
            if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                errors++; $display("FAIL async_restore c=%0d got %h/%b/%b exp %h/%0d/%0d", c, addr, ls, fs, m_addr, m_ls, m_fs);
            end
            if (c == 0) begin
                checks++;
                if (addr !== ADDR_W'(300)) begin
                    errors++; $display("FAIL async_vs_base got %0d exp 300", addr);
                end
            end
        end
    endtask

    task automatic test_random();
        int vs_len, npix, nlines, l;
        for (int f = 0; f < 8; f++) begin
            mode   = 2'($urandom_range(0, 3));
            xs     = 10'($urandom);
            ys     = 10'($urandom);
            base   = 14'($urandom);
            stride = 14'($urandom_range(0, 4095));
            vs_len = $urandom_range(2, 4);
            npix   = $urandom_range(1, 20);
            nlines = $urandom_range(2, 10);
            for (int c = 0; c < vs_len + nlines * (npix + 4); c++) begin
                set_frame(c, vs_len, npix);
                if (c >= vs_len) begin
                    l = (c - vs_len) / (npix + 4);
                    if ((l % 5) == 3) visy = 1'b0;
                end
                en = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 29) == 0) begin
                    xs = 10'($urandom); ys = 10'($urandom); mode = 2'($urandom_range(0, 3));
                    base = 14'($urandom); stride = 14'($urandom);
                end
                if ($urandom_range(0, 149) == 0) vs = 1'b1;
                tick();
                checks++;
                if ({addr, ls, fs} !== {ADDR_W'(m_addr), 1'(m_ls), 1'(m_fs)}) begin
                    errors++; $display("FAIL random f=%0d c=%0d got %h/%b/%b exp %h/%0d/%0d", f, c, addr, ls, fs, m_addr, m_ls, m_fs);
                end
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_native();
        test_scaled();
        test_clamp();
        test_shadow();
        test_enable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
